// File: rtl/rsa256_tx_sender_if.sv
// Port bundle for the RSA256 egress sender: the result-word handshake from
// Rsa256Core plus the Avalon-MM master bus toward the RS232 UART.
interface rsa256_tx_sender_if;
  logic [255:0] i_data;
  logic         i_valid;
  logic         o_ready;
  logic         o_done;
  logic [4:0]   o_avm_address;
  logic         o_avm_read;
  logic         o_avm_write;
  logic [31:0]  o_avm_writedata;
  logic [31:0]  i_avm_readdata;
  logic         i_avm_waitrequest;

  // Sender side: owns the ready/done flags and the Avalon strobes.
  modport master (
    input  i_data, i_valid, i_avm_readdata, i_avm_waitrequest,
    output o_ready, o_done, o_avm_address, o_avm_read, o_avm_write, o_avm_writedata
  );

  // Environment side: producer of the word and the UART slave.
  modport slave (
    output i_data, i_valid, i_avm_readdata, i_avm_waitrequest,
    input  o_ready, o_done, o_avm_address, o_avm_read, o_avm_write, o_avm_writedata
  );
endinterface

// File: rtl/rsa256_tx_sender.sv
// RSA256 egress sender: takes one result word, then for each byte (MSB first)
// polls the UART status register until TX is free and writes the byte to the
// TX data register. Every output comes straight from a flop.
module rsa256_tx_sender #(
  parameter int         NUM_BYTES   = 31,
  parameter logic [4:0] STATUS_ADDR = 5'd8,
  parameter logic [4:0] TX_ADDR     = 5'd4,
  parameter int         TX_OK_BIT   = 6
) (
  input logic              i_clk,
  input logic              i_rst,
  rsa256_tx_sender_if.master bus
);

  localparam int          SW       = 8 * NUM_BYTES;
  localparam logic [5:0]  LAST_CNT = 6'(NUM_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_POLL, S_WRITE, S_DONE} state_t;

  state_t        state_r, state_s;
  logic [SW-1:0] shift_r, shift_s;
  logic [5:0]    cnt_r, cnt_s;

  logic          ready_r, ready_s;
  logic          done_r, done_s;
  logic          read_r, read_s;
  logic          write_r, write_s;
  logic [4:0]    address_r, address_s;
  logic [31:0]   writedata_r, writedata_s;

  // Next-state logic: the shift register only moves when a byte write is accepted.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (bus.i_valid) begin
          shift_s = bus.i_data[SW-1:0];
          cnt_s   = 6'd0;
          state_s = S_POLL;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_POLL: begin
        if (!bus.i_avm_waitrequest) begin
          if (bus.i_avm_readdata[TX_OK_BIT]) begin
            state_s = S_WRITE;
          end else begin
            state_s = S_POLL;
          end
        end else begin
          state_s = S_POLL;
        end
      end
      S_WRITE: begin
        if (!bus.i_avm_waitrequest) begin
          shift_s = shift_r << 4'd8;
          cnt_s   = cnt_r + 6'd1;
          if (cnt_r == LAST_CNT) begin
            state_s = S_DONE;
          end else begin
            state_s = S_POLL;
          end
        end else begin
          state_s = S_WRITE;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the flops present it next cycle.
  always_comb begin
    ready_s     = 1'b0;
    done_s      = 1'b0;
    read_s      = 1'b0;
    write_s     = 1'b0;
    address_s   = STATUS_ADDR;
    writedata_s = 32'd0;
    case (state_s)
      S_IDLE:  ready_s = 1'b1;
      S_POLL:  read_s  = 1'b1;
      S_WRITE: begin
        write_s     = 1'b1;
        address_s   = TX_ADDR;
        writedata_s = {24'd0, shift_s[SW-1 -: 8]};
      end
      S_DONE:  done_s  = 1'b1;
      default: ready_s = 1'b0;
    endcase
  end

  // State, datapath and output registers; reset wins over everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= S_IDLE;
      shift_r     <= {SW{1'b0}};
      cnt_r       <= 6'd0;
      ready_r     <= 1'b1;
      done_r      <= 1'b0;
      read_r      <= 1'b0;
      write_r     <= 1'b0;
      address_r   <= STATUS_ADDR;
      writedata_r <= 32'd0;
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      cnt_r       <= cnt_s;
      ready_r     <= ready_s;
      done_r      <= done_s;
      read_r      <= read_s;
      write_r     <= write_s;
      address_r   <= address_s;
      writedata_r <= writedata_s;
    end
  end

  assign bus.o_ready         = ready_r;
  assign bus.o_done          = done_r;
  assign bus.o_avm_read      = read_r;
  assign bus.o_avm_write     = write_r;
  assign bus.o_avm_address   = address_r;
  assign bus.o_avm_writedata = writedata_r;

endmodule

// File: doc/rsa256_tx_sender.md
Name: rsa256_tx_sender

Overview:
Egress half of the RSA256 datapath. It accepts one 256-bit result word from Rsa256Core (o_a_pow_e) through a valid/ready handshake. It then streams the word byte by byte, MSB-first, to the RS232 UART IP over an Avalon-MM master port. Before each byte it polls the UART status register until TX is ready. It is the transmit-side counterpart of the wrapper logic that reads key and ciphertext bytes from the same UART.

Parameters:
NUM_BYTES, 31, bytes sent per word, legal range 1..32; the lowest 8*NUM_BYTES bits of i_data are sent.
STATUS_ADDR, 5'd8, Avalon address of the UART status register.
TX_ADDR, 5'd4, Avalon address of the UART TX data register.
TX_OK_BIT, 6, status bit that is 1 when the UART can accept a TX byte.

Ports:
i_clk  in  1  clock; all logic on the rising edge.
i_rst  in  1  reset, synchronous, active-high.
i_data  in  256  result word from Rsa256Core.
i_valid  in  1  i_data is valid.
o_ready  out  1  block is idle and accepts a word.
o_done  out  1  one-cycle pulse after the last byte write is accepted.
o_avm_address  out  5  Avalon address.
o_avm_read  out  1  Avalon read strobe.
o_avm_write  out  1  Avalon write strobe.
o_avm_writedata  out  32  Avalon write data; bits 31:8 are always 0.
i_avm_readdata  in  32  Avalon read data.
i_avm_waitrequest  in  1  Avalon stall.

Behaviour:
- Reset (i_rst=1 at an edge) has these effects:
  - state returns to S_IDLE; o_ready=1, o_done=0, o_avm_read=0, o_avm_write=0;
  - o_avm_address=STATUS_ADDR, o_avm_writedata=0;
  - shift register and byte counter are cleared;
  - reset overrides every other input that cycle.
- All outputs are driven from registers only. There is no combinational path from an input to an output.
- State machine states: S_IDLE, S_POLL, S_WRITE, S_DONE.
- S_IDLE:
  - o_ready=1.
  - At an edge with i_valid=1: latch i_data[8*NUM_BYTES-1:0] into the shift register, set cnt=0, go to S_POLL.
- S_POLL:
  - o_avm_read=1, o_avm_address=STATUS_ADDR.
  - At an edge with waitrequest=0, sample i_avm_readdata[TX_OK_BIT]. If 1, go to S_WRITE. If 0, stay in S_POLL; read remains asserted and a fresh read is issued.
  - While waitrequest=1, nothing is sampled and all outputs are held.
- S_WRITE:
  - o_avm_write=1, o_avm_address=TX_ADDR, o_avm_writedata={24'b0, top byte of shift register}.
  - Outputs are held stable while waitrequest=1.
  - At an edge with waitrequest=0:
    - the shift register moves left 8 bits and cnt increments;
    - if cnt was NUM_BYTES-1, go to S_DONE, otherwise go to S_POLL.
- S_DONE: o_done=1 for exactly one cycle, then S_IDLE.
- o_avm_read and o_avm_write are never asserted in the same cycle. Neither is asserted in S_IDLE or S_DONE.
- Byte order: the first byte sent is i_data[8*NUM_BYTES-1 -: 8]; the last is i_data[7:0]. Bits above 8*NUM_BYTES are ignored.
- While not in S_IDLE, o_ready=0 and i_valid is ignored; the word is not queued.
- Latency with waitrequest=0 and TX always ready:
  - word accepted at edge 0;
  - bus activity in cycles 1..2*NUM_BYTES;
  - o_done=1 in cycle 2*NUM_BYTES+1;
  - o_ready=1 again in cycle 2*NUM_BYTES+2.
- Reset during a transfer aborts it immediately. No further read or write is issued, the remaining bytes are discarded, and o_done is not pulsed.
- A word with i_valid=1 in the same cycle o_ready returns to 1 is accepted at that edge. Back-to-back words need no idle gap beyond S_DONE.
- The block tolerates an indefinite waitrequest stall and an indefinitely busy TX (no timeout).

Test Plan:
1. Basic send: NUM_BYTES=31, i_data=256'h00_0102…1F (byte k = k+1), status=32'h40, waitrequest=0 -> exactly 31 writes to address 4 with data 32'h01..32'h1F in order. Each write follows one status read. o_done pulses in cycle 63. Bits 255:248 are never sent.
2. TX busy: status=32'h00 for the first 5 polls, then 32'h40 -> 6 reads to address 8 and no write until the 6th read returns TX_OK. The byte sequence is otherwise unchanged.
3. Waitrequest stall: hold waitrequest=1 for 3 cycles on the 2nd write and 2 cycles on the 4th poll -> address, writedata and strobes stable during the stall; exactly one write is accepted per byte; the total written sequence matches scenario 1.
4. Reset mid-operation: assert i_rst for 1 cycle after the 10th byte write is accepted -> next cycle o_avm_read=o_avm_write=0, o_ready=1, o_done never pulses. A new word sent afterwards starts from its own top byte.
5. Back-to-back with i_valid held: two words 256'hAA… then 256'h55… with i_valid held high -> the second word is accepted in the cycle after o_done, and i_valid is ignored during the first transfer. Expect 62 writes: 31 × 8'hAA then 31 × 8'h55.
6. Parameter variant NUM_BYTES=32, i_data={8'hFE, 248'h0…01} -> the first byte written is 8'hFE, the last is 8'h01, with 32 writes total.
